risc5_pipe_ctrl: RTL and testbench

- Parametrised hazard and pipeline-control unit for the 5-stage RISC-V core (IF, ID, EX, MEM, WB).
- Supersedes the stall/flush/forward decisions currently scattered across ID, EX and the top level.
- New over the existing core: a multi-cycle data-memory wait FSM with configurable latency, explicit per-stage hold/bubble controls, and unified priority resolution of wait, load-use, branch and jump.

---
 rtl/risc5_pipe_ctrl.sv | 167 ++++++++++++++++
 tb/tb_risc5_pipe_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/risc5_pipe_ctrl.sv
// rtl/risc5_pipe_ctrl.sv - hazard, stall/flush and forwarding control for the 5-stage core
// Optional macro RISC5_PIPE_PERF_EN adds saturating stall/flush/wait counters.
module risc5_pipe_ctrl #(
    parameter int RA_W    = 5,
    parameter int MEM_LAT = 0,
    parameter int CNT_W   = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [RA_W-1:0] rs1_addr_id_i,
    input  logic [RA_W-1:0] rs2_addr_id_i,
    input  logic            rs1_used_id_i,
    input  logic            rs2_used_id_i,
    input  logic [RA_W-1:0] rs1_addr_ex_i,
    input  logic [RA_W-1:0] rs2_addr_ex_i,
    input  logic [RA_W-1:0] rd_addr_ex_i,
    input  logic            mem_read_ex_i,
    input  logic            reg_write_ex_i,
    input  logic [RA_W-1:0] rd_addr_mem_i,
    input  logic            reg_write_mem_i,
    input  logic            mem_acc_mem_i,
    input  logic [RA_W-1:0] rd_addr_wb_i,
    input  logic            reg_write_wb_i,
    input  logic            branch_i,
    input  logic            jump_i,
    output logic            pc_write_o,
    output logic            if_write_o,
    output logic            if_flush_o,
    output logic            idex_write_o,
    output logic            id_ex_bubble_o,
    output logic            exmem_write_o,
    output logic            mem_wb_bubble_o,
    output logic [1:0]      forward_a_o,
    output logic [1:0]      forward_b_o,
    output logic            stall_o,
    output logic            mem_busy_o
`ifdef RISC5_PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] wait_cnt_o
`endif
);

    typedef enum logic {S_RUN, S_WAIT} state_e;

    localparam bit         HAS_WAIT = (MEM_LAT > 0);
    localparam logic [3:0] LAT_M1   = HAS_WAIT ? 4'(MEM_LAT - 1) : 4'd0;

    state_e     state_q;
    logic [3:0] wcnt_q;
    logic       done_q;

    logic mem_trig, mem_freeze, load_use, ctrl_flush;
    logic unused_ex;

    assign unused_ex = reg_write_ex_i;

    // done_q blocks a retrigger from the same access while EX_MEM is still holding it
    assign mem_trig   = (state_q == S_RUN) && mem_acc_mem_i && HAS_WAIT && !done_q;
    assign mem_freeze = mem_trig || (state_q == S_WAIT);
    assign load_use   = mem_read_ex_i && (rd_addr_ex_i != '0) &&
                        ((rs1_used_id_i && (rs1_addr_id_i == rd_addr_ex_i)) ||
                         (rs2_used_id_i && (rs2_addr_id_i == rd_addr_ex_i)));
    assign ctrl_flush = branch_i || jump_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_RUN;
            wcnt_q  <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    done_q <= 1'b0;
                    if (mem_trig) begin
                        state_q <= S_WAIT;
                        wcnt_q  <= LAT_M1;
                    end
                end
                S_WAIT: begin
                    if (wcnt_q == 4'd0) begin
                        state_q <= S_RUN;
                        done_q  <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs,
                                           input logic            we_mem,
                                           input logic [RA_W-1:0] rd_mem,
                                           input logic            we_wb,
                                           input logic [RA_W-1:0] rd_wb);
        if (we_mem && (rd_mem != '0) && (rd_mem == rs)) return 2'b01;
        if (we_wb && (rd_wb != '0) && (rd_wb == rs))    return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        pc_write_o      = 1'b1;
        if_write_o      = 1'b1;
        if_flush_o      = 1'b0;
        idex_write_o    = 1'b1;
        id_ex_bubble_o  = 1'b0;
        exmem_write_o   = 1'b1;
        mem_wb_bubble_o = 1'b0;
        stall_o         = 1'b0;
        mem_busy_o      = 1'b0;
        forward_a_o     = fwd_sel(rs1_addr_ex_i, reg_write_mem_i, rd_addr_mem_i,
                                  reg_write_wb_i, rd_addr_wb_i);
        forward_b_o     = fwd_sel(rs2_addr_ex_i, reg_write_mem_i, rd_addr_mem_i,
                                  reg_write_wb_i, rd_addr_wb_i);
        if (!rst_ni) begin
            pc_write_o      = 1'b0;
            if_write_o      = 1'b0;
            if_flush_o      = 1'b1;
            id_ex_bubble_o  = 1'b1;
            mem_wb_bubble_o = 1'b1;
            forward_a_o     = 2'b00;
            forward_b_o     = 2'b00;
        end else if (mem_freeze) begin
            pc_write_o      = 1'b0;
            if_write_o      = 1'b0;
            idex_write_o    = 1'b0;
            exmem_write_o   = 1'b0;
            mem_wb_bubble_o = 1'b1;
            stall_o         = 1'b1;
            mem_busy_o      = (state_q == S_WAIT);
        end else if (load_use) begin
            // ID operands are stale, so a taken branch/jump waits for the retry
            pc_write_o     = 1'b0;
            if_write_o     = 1'b0;
            id_ex_bubble_o = 1'b1;
            stall_o        = 1'b1;
        end else if (ctrl_flush) begin
            if_flush_o = 1'b1;
        end
    end

`ifdef RISC5_PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            if (load_use && !mem_freeze && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (if_flush_o && !(&flush_cnt_q))              flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if (mem_freeze && !(&wait_cnt_q))               wait_cnt_q  <= wait_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign wait_cnt_o  = wait_cnt_q;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_risc5_pipe_ctrl.sv
// tb/tb_risc5_pipe_ctrl.sv - scoreboard bench for risc5_pipe_ctrl (MEM_LAT=3 and MEM_LAT=0 side by side)
module tb_risc5_pipe_ctrl;
    localparam int RA_W  = 5;
    localparam int LAT   = 3;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [RA_W-1:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic            rs1_used, rs2_used, mem_read_ex, rw_ex, rw_mem, mem_acc, rw_wb, branch, jump;

    logic       pcw3, ifw3, iff3, idw3, idb3, emw3, mwb3, st3, mb3;
    logic [1:0] fa3, fb3;
    logic       pcw0, ifw0, iff0, idw0, idb0, emw0, mwb0, st0, mb0;
    logic [1:0] fa0, fb0;
`ifdef RISC5_PIPE_PERF_EN
    logic [CNT_W-1:0] scnt3, fcnt3, wcnt3, scnt0, fcnt0, wcnt0;
`endif

    risc5_pipe_ctrl #(.RA_W(RA_W), .MEM_LAT(LAT), .CNT_W(CNT_W)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rs1_addr_id_i(rs1_id), .rs2_addr_id_i(rs2_id),
        .rs1_used_id_i(rs1_used), .rs2_used_id_i(rs2_used),
        .rs1_addr_ex_i(rs1_ex), .rs2_addr_ex_i(rs2_ex),
        .rd_addr_ex_i(rd_ex), .mem_read_ex_i(mem_read_ex), .reg_write_ex_i(rw_ex),
        .rd_addr_mem_i(rd_mem), .reg_write_mem_i(rw_mem), .mem_acc_mem_i(mem_acc),
        .rd_addr_wb_i(rd_wb), .reg_write_wb_i(rw_wb),
        .branch_i(branch), .jump_i(jump),
        .pc_write_o(pcw3), .if_write_o(ifw3), .if_flush_o(iff3),
        .idex_write_o(idw3), .id_ex_bubble_o(idb3), .exmem_write_o(emw3),
        .mem_wb_bubble_o(mwb3), .forward_a_o(fa3), .forward_b_o(fb3),
        .stall_o(st3), .mem_busy_o(mb3)
`ifdef RISC5_PIPE_PERF_EN
        , .stall_cnt_o(scnt3), .flush_cnt_o(fcnt3), .wait_cnt_o(wcnt3)
`endif
    );

    risc5_pipe_ctrl #(.RA_W(RA_W), .MEM_LAT(0), .CNT_W(CNT_W)) u_lat0 (
        .clk_i(clk), .rst_ni(rst_n),
        .rs1_addr_id_i(rs1_id), .rs2_addr_id_i(rs2_id),
        .rs1_used_id_i(rs1_used), .rs2_used_id_i(rs2_used),
        .rs1_addr_ex_i(rs1_ex), .rs2_addr_ex_i(rs2_ex),
        .rd_addr_ex_i(rd_ex), .mem_read_ex_i(mem_read_ex), .reg_write_ex_i(rw_ex),
        .rd_addr_mem_i(rd_mem), .reg_write_mem_i(rw_mem), .mem_acc_mem_i(mem_acc),
        .rd_addr_wb_i(rd_wb), .reg_write_wb_i(rw_wb),
        .branch_i(branch), .jump_i(jump),
        .pc_write_o(pcw0), .if_write_o(ifw0), .if_flush_o(iff0),
        .idex_write_o(idw0), .id_ex_bubble_o(idb0), .exmem_write_o(emw0),
        .mem_wb_bubble_o(mwb0), .forward_a_o(fa0), .forward_b_o(fb0),
        .stall_o(st0), .mem_busy_o(mb0)
`ifdef RISC5_PIPE_PERF_EN
        , .stall_cnt_o(scnt0), .flush_cnt_o(fcnt0), .wait_cnt_o(wcnt0)
`endif
    );

    // {pc_write, if_write, if_flush, idex_write, id_ex_bubble, exmem_write, mem_wb_bubble, fwd_a, fwd_b, stall, mem_busy}
    logic [12:0] obs3, obs0;
    assign obs3 = {pcw3, ifw3, iff3, idw3, idb3, emw3, mwb3, fa3, fb3, st3, mb3};
    assign obs0 = {pcw0, ifw0, iff0, idw0, idb0, emw0, mwb0, fa0, fb0, st0, mb0};

    typedef struct {
        string       tag;
        logic [12:0] e3;
        logic [12:0] e0;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] ev_run(input logic [1:0] fa, input logic [1:0] fb);
        return {7'b1101010, fa, fb, 2'b00};
    endfunction
    function automatic logic [12:0] ev_frz(input logic busy);
        return {7'b0000001, 4'b0000, 1'b1, busy};
    endfunction
    function automatic logic [12:0] ev_lu();
        return {7'b0001110, 4'b0000, 2'b10};
    endfunction
    function automatic logic [12:0] ev_fl();
        return {7'b1111010, 4'b0000, 2'b00};
    endfunction
    function automatic logic [12:0] ev_rst();
        return {7'b0011111, 4'b0000, 2'b00};
    endfunction

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.tag, "/lat3"}, {19'd0, obs3}, {19'd0, e.e3});
            check({e.tag, "/lat0"}, {19'd0, obs0}, {19'd0, e.e0});
        end
    end

    task automatic step(input string tag, input logic [12:0] e3, input logic [12:0] e0);
        exp_t e;
        e.tag = tag;
        e.e3  = e3;
        e.e0  = e0;
        sb_q.push_back(e);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rs1_id = '0; rs2_id = '0; rs1_ex = '0; rs2_ex = '0;
        rd_ex = '0; rd_mem = '0; rd_wb = '0;
        rs1_used = 1'b0; rs2_used = 1'b0; mem_read_ex = 1'b0; rw_ex = 1'b0;
        rw_mem = 1'b0; mem_acc = 1'b0; rw_wb = 1'b0; branch = 1'b0; jump = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        #1;
        mem_acc = 1'b1;
        step("reset_hold", ev_rst(), ev_rst());
        rst_n = 1'b1;
        clr();
        step("idle", ev_run(2'b00, 2'b00), ev_run(2'b00, 2'b00));

        // load-use on rs1, then the load drains through MEM to WB
        mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs1_used = 1'b1;
        step("lu_rs1", ev_lu(), ev_lu());
        clr(); rw_mem = 1'b1; rd_mem = 5'd5; rs1_id = 5'd5; rs1_used = 1'b1;
        step("lu_retry", ev_run(2'b00, 2'b00), ev_run(2'b00, 2'b00));
        clr(); rw_wb = 1'b1; rd_wb = 5'd5; rs1_ex = 5'd5;
        step("lu_fwd_wb", ev_run(2'b10, 2'b00), ev_run(2'b10, 2'b00));
        clr(); mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5;
        step("lu_src_unused", ev_run(2'b00, 2'b00), ev_run(2'b00, 2'b00));
        clr(); mem_read_ex = 1'b1; rs1_used = 1'b1;
        step("lu_x0", ev_run(2'b00, 2'b00), ev_run(2'b00, 2'b00));
        clr(); rd_ex = 5'd5; rs1_id = 5'd5; rs1_used = 1'b1;
        step("no_load", ev_run(2'b00, 2'b00), ev_run(2'b00, 2'b00));

        // load-use suppresses jump flush, flush follows once cleared
        clr(); jump = 1'b1; mem_read_ex = 1'b1; rd_ex = 5'd7; rs2_used = 1'b1; rs2_id = 5'd7;
        step("jump_lu", ev_lu(), ev_lu());
        mem_read_ex = 1'b0; rd_ex = '0;
        step("jump_after_lu", ev_fl(), ev_fl());
        clr(); branch = 1'b1;
        step("branch", ev_fl(), ev_fl());

        // forwarding priority and x0 exclusion
        clr(); rw_mem = 1'b1; rd_mem = 5'd3; rw_wb = 1'b1; rd_wb = 5'd3; rs1_ex = 5'd3;
        step("fwd_mem_beats_wb", ev_run(2'b01, 2'b00), ev_run(2'b01, 2'b00));
        rd_mem = 5'd0;
        step("fwd_mem_rd_x0", ev_run(2'b10, 2'b00), ev_run(2'b10, 2'b00));
        rd_mem = 5'd3; rw_mem = 1'b0; rs2_ex = 5'd3;
        step("fwd_wb_both", ev_run(2'b10, 2'b10), ev_run(2'b10, 2'b10));
        rw_mem = 1'b1; rd_mem = 5'd4; rs2_ex = 5'd4;
        step("fwd_split", ev_run(2'b10, 2'b01), ev_run(2'b10, 2'b01));
        clr(); rw_wb = 1'b1;
        step("fwd_wb_x0", ev_run(2'b00, 2'b00), ev_run(2'b00, 2'b00));

        // memory wait: LAT+1 freeze cycles, branch and load-use ignored while frozen
        clr(); mem_acc = 1'b1;
        step("mw_trig", ev_frz(1'b0), ev_run(2'b00, 2'b00));
        branch = 1'b1;
        step("mw_wait1_branch", ev_frz(1'b1), ev_fl());
        branch = 1'b0; mem_read_ex = 1'b1; rd_ex = 5'd9; rs2_id = 5'd9; rs2_used = 1'b1;
        step("mw_wait2_lu", ev_frz(1'b1), ev_lu());
        clr(); mem_acc = 1'b1;
        step("mw_wait3", ev_frz(1'b1), ev_run(2'b00, 2'b00));
        step("mw_done_no_retrig", ev_run(2'b00, 2'b00), ev_run(2'b00, 2'b00));
        mem_acc = 1'b0;
        step("mw_idle", ev_run(2'b00, 2'b00), ev_run(2'b00, 2'b00));

        // reset during WAIT abandons the access; a new access gets the full freeze
        mem_acc = 1'b1;
        step("rw_trig", ev_frz(1'b0), ev_run(2'b00, 2'b00));
        step("rw_wait1", ev_frz(1'b1), ev_run(2'b00, 2'b00));
        step("rw_wait2", ev_frz(1'b1), ev_run(2'b00, 2'b00));
        rst_n = 1'b0;
        step("rw_reset", ev_rst(), ev_rst());
        rst_n = 1'b1;
        step("rr_trig", ev_frz(1'b0), ev_run(2'b00, 2'b00));
        for (int i = 0; i < LAT; i++)
            step($sformatf("rr_wait%0d", i), ev_frz(1'b1), ev_run(2'b00, 2'b00));
        step("rr_done", ev_run(2'b00, 2'b00), ev_run(2'b00, 2'b00));
        mem_acc = 1'b0;
        step("rr_idle", ev_run(2'b00, 2'b00), ev_run(2'b00, 2'b00));

`ifdef RISC5_PIPE_PERF_EN
        rst_n = 1'b0;
        step("perf_reset", ev_rst(), ev_rst());
        rst_n = 1'b1;
        clr(); mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs1_used = 1'b1;
        for (int i = 0; i < 20; i++)
            step("perf_lu", ev_lu(), ev_lu());
        check("stall_cnt_sat/lat3", 32'(scnt3), ((1 << CNT_W) - 1 < 20) ? (1 << CNT_W) - 1 : 20);
        check("stall_cnt_sat/lat0", 32'(scnt0), ((1 << CNT_W) - 1 < 20) ? (1 << CNT_W) - 1 : 20);
        check("flush_cnt/lat3", 32'(fcnt3), 32'd0);
        check("wait_cnt/lat3", 32'(wcnt3), 32'd0);
        clr();
`endif

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
